// File: rtl/sccb_pkg.sv
// Shared encodings for the SCCB register-access master.
package sccb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StTxByte,
    StAck,
    StRdByte,
    StMnack,
    StStop,
    StGap
  } sccb_state_e;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  // LSB of the slave-ID byte
  localparam logic SCCB_WR = 1'b0;
  localparam logic SCCB_RD = 1'b1;

endpackage

// File: rtl/sccb_bit_timer.sv
// Quarter-bit divider and phase counter; held cleared while run is low.
module sccb_bit_timer #(
  parameter int unsigned QTR = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic [1:0] phase,
  output logic       qtr_end,
  output logic       bit_end
);
  import sccb_pkg::*;

  localparam int unsigned CW = (QTR > 1) ? $clog2(QTR) : 1;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_phase;

  assign phase   = r_phase;
  assign qtr_end = run && (r_cnt == CW'(QTR - 1));
  assign bit_end = qtr_end && (r_phase == PH3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= PH0;
    end else if (!run) begin
      r_cnt   <= '0;
      r_phase <= PH0;
    end else if (qtr_end) begin
      r_cnt   <= '0;
      r_phase <= r_phase + 2'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sccb_master_rw.sv
// SCCB/I2C-style master: 3-phase register writes and 2-phase reads over open-drain SDA/SCL.
module sccb_master_rw
  import sccb_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 24_000_000,
  parameter int unsigned SCCB_FREQ_HZ = 100_000,
  parameter logic [6:0]  DEV_ADDR     = 7'h21,
  parameter int unsigned REG_ADDR_W   = 8,
  parameter bit          CHECK_ACK    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  rw,
  input  logic [REG_ADDR_W-1:0] reg_addr,
  input  logic [7:0]            wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  nack,
  output logic [7:0]            rdata,
  output logic                  scl_o,
  output logic                  sda_oe,
  input  logic                  sda_i
);

  localparam int unsigned QTR = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam logic [1:0]  NA  = 2'(REG_ADDR_W / 8);

  sccb_state_e r_state, w_state_next;
  logic        r_rw, r_rd_phase, r_nack, r_oe_hold;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata, r_shadow, r_rdata, w_tx_byte;
  logic [2:0]  r_bit;
  logic [1:0]  r_byte, w_phase;
  logic        w_qtr_end, w_bit_end, w_sample, w_final, w_accept;

  sccb_bit_timer #(.QTR(QTR)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (busy),
    .phase   (w_phase),
    .qtr_end (w_qtr_end),
    .bit_end (w_bit_end)
  );

  assign busy     = (r_state != StIdle);
  assign w_accept = start && !busy;
  assign w_sample = w_qtr_end && (w_phase == PH2);
  // Only the address phase of a read is followed by GAP instead of finishing
  assign w_final  = (r_rw == SCCB_WR) || r_rd_phase || (CHECK_ACK && r_nack);
  assign done     = (r_state == StStop) && w_bit_end && w_final;
  assign nack     = r_nack;
  assign rdata    = r_rdata;

  always_comb begin
    w_tx_byte = r_addr[7:0];
    if (r_rd_phase)                      w_tx_byte = {DEV_ADDR, SCCB_RD};
    else if (r_byte == 2'd0)             w_tx_byte = {DEV_ADDR, SCCB_WR};
    else if (r_byte == NA + 2'd1)        w_tx_byte = r_wdata;
    else if (NA == 2'd2 && r_byte == 2'd1) w_tx_byte = r_addr[15:8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    scl_o        = 1'b1;
    sda_oe       = 1'b0;
    unique case (r_state)
      StIdle:   if (start) w_state_next = StStart;
      StStart: begin
        sda_oe = w_phase[1];
        if (w_bit_end) w_state_next = StTxByte;
      end
      StTxByte: begin
        scl_o  = w_phase[1];
        // SDA keeps the previous slot's level through ph0
        sda_oe = (w_phase == PH0) ? r_oe_hold : ~w_tx_byte[~r_bit];
        if (w_bit_end && r_bit == 3'd7) w_state_next = StAck;
      end
      StAck: begin
        scl_o  = w_phase[1];
        sda_oe = (w_phase == PH0) ? r_oe_hold : 1'b0;
        if (w_bit_end) begin
          if (CHECK_ACK && r_nack)            w_state_next = StStop;
          else if (r_rd_phase)                w_state_next = StRdByte;
          else if (r_rw == SCCB_WR ? (r_byte == NA + 2'd1) : (r_byte == NA))
                                              w_state_next = StStop;
          else                                w_state_next = StTxByte;
        end
      end
      StRdByte: begin
        scl_o  = w_phase[1];
        sda_oe = (w_phase == PH0) ? r_oe_hold : 1'b0;
        if (w_bit_end && r_bit == 3'd7) w_state_next = StMnack;
      end
      StMnack: begin
        scl_o  = w_phase[1];
        sda_oe = (w_phase == PH0) ? r_oe_hold : 1'b0;
        if (w_bit_end) w_state_next = StStop;
      end
      StStop: begin
        scl_o  = (w_phase != PH0);
        sda_oe = ~w_phase[1];
        if (w_bit_end) w_state_next = w_final ? StIdle : StGap;
      end
      StGap:    if (w_bit_end) w_state_next = StStart;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rw       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_rd_phase <= 1'b0;
      r_nack     <= 1'b0;
      r_oe_hold  <= 1'b0;
      r_shadow   <= '0;
      r_rdata    <= '0;
    end else if (w_accept) begin
      r_rw       <= rw;
      r_addr     <= 16'(reg_addr);
      r_wdata    <= wdata;
      r_bit      <= '0;
      r_byte     <= '0;
      r_rd_phase <= 1'b0;
      r_nack     <= 1'b0;
      r_oe_hold  <= 1'b0;
    end else if (busy) begin
      if (w_sample && r_state == StAck && sda_i)  r_nack   <= 1'b1;
      if (w_sample && r_state == StRdByte)        r_shadow <= {r_shadow[6:0], sda_i};
      if (w_bit_end) begin
        r_oe_hold <= sda_oe;
        // 3-bit counter wraps 7->0 at each byte end
        if (r_state == StTxByte || r_state == StRdByte) r_bit <= r_bit + 3'd1;
        if (r_state == StAck && w_state_next == StTxByte) r_byte <= r_byte + 2'd1;
        if (r_state == StGap) r_rd_phase <= 1'b1;
      end
      if (done && r_rw == SCCB_RD && !r_nack) r_rdata <= r_shadow;
    end
  end

endmodule

// File: tb/tb_sccb_master_rw.sv
// Directed bench: three master instances share one behavioural SCCB slave selected by sel.
module tb_sccb_master_rw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rw = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;
  int          sel = 0;

  logic [2:0] busy_v, done_v, nack_v, scl_v, oe_v, sda_in_v;
  logic [7:0] rdata_v [3];
  logic       pull = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_sda
    assign sda_in_v[k] = !(oe_v[k] || (sel == k && pull));
  end

  sccb_master_rw #(.CLK_FREQ_HZ(400_000), .SCCB_FREQ_HZ(25_000), .REG_ADDR_W(8),
                   .CHECK_ACK(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 0), .rw(rw), .reg_addr(addr[7:0]),
    .wdata(wdata), .busy(busy_v[0]), .done(done_v[0]), .nack(nack_v[0]), .rdata(rdata_v[0]),
    .scl_o(scl_v[0]), .sda_oe(oe_v[0]), .sda_i(sda_in_v[0])
  );

  sccb_master_rw #(.CLK_FREQ_HZ(400_000), .SCCB_FREQ_HZ(25_000), .REG_ADDR_W(16),
                   .CHECK_ACK(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 1), .rw(rw), .reg_addr(addr),
    .wdata(wdata), .busy(busy_v[1]), .done(done_v[1]), .nack(nack_v[1]), .rdata(rdata_v[1]),
    .scl_o(scl_v[1]), .sda_oe(oe_v[1]), .sda_i(sda_in_v[1])
  );

  sccb_master_rw #(.CLK_FREQ_HZ(400_000), .SCCB_FREQ_HZ(25_000), .REG_ADDR_W(8),
                   .CHECK_ACK(1'b0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 2), .rw(rw), .reg_addr(addr[7:0]),
    .wdata(wdata), .busy(busy_v[2]), .done(done_v[2]), .nack(nack_v[2]), .rdata(rdata_v[2]),
    .scl_o(scl_v[2]), .sda_oe(oe_v[2]), .sda_i(sda_in_v[2])
  );

  // Behavioural slave, sampled on negedge so it never races the DUT's posedge logic
  logic       p_scl = 1'b1, p_sda = 1'b1;
  int         nbits = 0, byte_n = 0, nack_idx = 0;
  bit         s_tx = 0, s_tx_next = 0, nack_en = 0, mnack_seen = 0;
  logic [7:0] sh = '0, rd_val = 8'h76;
  string      log_s = "";

  always @(negedge clk) begin
    logic cs, cd;
    cs = scl_v[sel];
    cd = sda_in_v[sel];
    if (p_scl && cs && p_sda && !cd) begin
      log_s = {log_s, "S "}; nbits = 0; byte_n = 0; s_tx = 0; s_tx_next = 0; pull = 0;
    end else if (p_scl && cs && !p_sda && cd) begin
      log_s = {log_s, "P "}; nbits = 0; s_tx = 0; pull = 0;
    end else if (!p_scl && cs) begin
      if (nbits < 8) sh = {sh[6:0], cd};
      else if (s_tx) mnack_seen = cd;
      nbits = (nbits == 8) ? 0 : nbits + 1;
    end else if (p_scl && !cs) begin
      if (nbits == 8) begin
        if (s_tx) pull = 0;
        else begin
          log_s = {log_s, $sformatf("%02h ", sh)};
          if (byte_n == 0 && sh == 8'h43) s_tx_next = 1;
          pull = !(nack_en && byte_n == nack_idx);
          byte_n++;
        end
      end else if (nbits == 0) begin
        pull = 0; s_tx = s_tx_next; s_tx_next = 0;
        if (s_tx) pull = !rd_val[7];
      end else if (s_tx) begin
        pull = !rd_val[7 - nbits];
      end
    end
    p_scl = cs;
    p_sda = cd;
  end

  task automatic run_txn(input int k, input bit r, input logic [15:0] a, input logic [7:0] d,
                         output int bcyc, output int dcnt);
    sel = k;
    log_s = "";
    @(negedge clk);
    start = 1; rw = r; addr = a; wdata = d;
    @(negedge clk);
    start = 0;
    bcyc = 0; dcnt = 0;
    while (busy_v[k] && bcyc < 3000) begin
      bcyc++;
      if (done_v[k]) dcnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (scl_v[0] !== 1'b1) begin failures++; $display("FAIL rst_scl got=%b exp=1", scl_v[0]); end
    if (oe_v[0] !== 1'b0) begin failures++; $display("FAIL rst_oe got=%b exp=0", oe_v[0]); end
    if (busy_v[0] !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_v[0]); end
    if (done_v[0] !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done_v[0]); end
    if (nack_v[0] !== 1'b0) begin failures++; $display("FAIL rst_nack got=%b exp=0", nack_v[0]); end
    if (rdata_v[0] !== 8'h00) begin
      failures++; $display("FAIL rst_rdata got=%h exp=00", rdata_v[0]);
    end
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write;
    int bc, dc;
    run_txn(0, 0, 16'h0012, 8'h80, bc, dc);
    checks += 4;
    if (bc != 464) begin failures++; $display("FAIL wr_busy got=%0d exp=464", bc); end
    if (dc != 1) begin failures++; $display("FAIL wr_done got=%0d exp=1", dc); end
    if (nack_v[0] !== 1'b0) begin failures++; $display("FAIL wr_nack got=%b exp=0", nack_v[0]); end
    if (log_s != "S 42 12 80 P ") begin
      failures++; $display("FAIL wr_bus got='%s' exp='S 42 12 80 P '", log_s);
    end
  endtask

  task automatic test_read;
    int bc, dc;
    rd_val = 8'h76; mnack_seen = 0;
    run_txn(0, 1, 16'h000A, 8'h00, bc, dc);
    checks += 6;
    if (bc != 656) begin failures++; $display("FAIL rd_busy got=%0d exp=656", bc); end
    if (dc != 1) begin failures++; $display("FAIL rd_done got=%0d exp=1", dc); end
    if (nack_v[0] !== 1'b0) begin failures++; $display("FAIL rd_nack got=%b exp=0", nack_v[0]); end
    if (rdata_v[0] !== 8'h76) begin
      failures++; $display("FAIL rd_data got=%h exp=76", rdata_v[0]);
    end
    if (mnack_seen !== 1'b1) begin failures++; $display("FAIL rd_mnack got=%b exp=1", mnack_seen); end
    if (log_s != "S 42 0a P S 43 P ") begin
      failures++; $display("FAIL rd_bus got='%s' exp='S 42 0a P S 43 P '", log_s);
    end
  endtask

  task automatic test_addr16;
    int bc, dc;
    run_txn(1, 0, 16'h3008, 8'h02, bc, dc);
    checks += 3;
    if (bc != 608) begin failures++; $display("FAIL a16_busy got=%0d exp=608", bc); end
    if (nack_v[1] !== 1'b0) begin failures++; $display("FAIL a16_nack got=%b exp=0", nack_v[1]); end
    if (log_s != "S 42 30 08 02 P ") begin
      failures++; $display("FAIL a16_bus got='%s' exp='S 42 30 08 02 P '", log_s);
    end
  endtask

  task automatic test_nack;
    int bc, dc;
    nack_en = 1; nack_idx = 0;
    rd_val = 8'h5A;
    run_txn(0, 1, 16'h000A, 8'h00, bc, dc);
    checks += 5;
    if (bc != 176) begin failures++; $display("FAIL nk_busy got=%0d exp=176", bc); end
    if (dc != 1) begin failures++; $display("FAIL nk_done got=%0d exp=1", dc); end
    if (nack_v[0] !== 1'b1) begin failures++; $display("FAIL nk_nack got=%b exp=1", nack_v[0]); end
    if (rdata_v[0] !== 8'h76) begin
      failures++; $display("FAIL nk_rdata got=%h exp=76", rdata_v[0]);
    end
    if (log_s != "S 42 P ") begin
      failures++; $display("FAIL nk_bus got='%s' exp='S 42 P '", log_s);
    end
    run_txn(2, 0, 16'h0012, 8'h80, bc, dc);
    checks += 3;
    if (bc != 464) begin failures++; $display("FAIL nk0_busy got=%0d exp=464", bc); end
    if (nack_v[2] !== 1'b1) begin failures++; $display("FAIL nk0_nack got=%b exp=1", nack_v[2]); end
    if (log_s != "S 42 12 80 P ") begin
      failures++; $display("FAIL nk0_bus got='%s' exp='S 42 12 80 P '", log_s);
    end
    nack_en = 0;
  endtask

  task automatic test_ignore_start;
    int bc, dc;
    sel = 0; log_s = "";
    @(negedge clk);
    start = 1; rw = 0; addr = 16'h0012; wdata = 8'h80;
    @(negedge clk);
    start = 0; bc = 0; dc = 0;
    while (busy_v[0] && bc < 3000) begin
      bc++;
      if (done_v[0]) dc++;
      if (bc == 100) begin start = 1; rw = 1; addr = 16'h0055; wdata = 8'h33; end
      if (bc == 101) start = 0;
      @(negedge clk);
    end
    checks += 3;
    if (bc != 464) begin failures++; $display("FAIL ign_busy got=%0d exp=464", bc); end
    if (dc != 1) begin failures++; $display("FAIL ign_done got=%0d exp=1", dc); end
    if (log_s != "S 42 12 80 P ") begin
      failures++; $display("FAIL ign_bus got='%s' exp='S 42 12 80 P '", log_s);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    sel = 2; nack_en = 1; nack_idx = 0;
    @(negedge clk);
    start = 1; rw = 0; addr = 16'h0012; wdata = 8'h80;
    n = 0;
    @(negedge clk);
    while (!done_v[2] && n < 3000) begin n++; @(negedge clk); end
    checks += 4;
    if (nack_v[2] !== 1'b1) begin failures++; $display("FAIL b2b_nack1 got=%b exp=1", nack_v[2]); end
    nack_en = 0; log_s = "";
    @(negedge clk);
    if (busy_v[2] !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%b exp=0", busy_v[2]); end
    @(negedge clk);
    if (busy_v[2] !== 1'b1) begin failures++; $display("FAIL b2b_acc got=%b exp=1", busy_v[2]); end
    if (nack_v[2] !== 1'b0) begin failures++; $display("FAIL b2b_clr got=%b exp=0", nack_v[2]); end
    start = 0; n = 0;
    while (busy_v[2] && n < 3000) begin n++; @(negedge clk); end
    checks += 3;
    if (n != 464) begin failures++; $display("FAIL b2b_busy got=%0d exp=464", n); end
    if (nack_v[2] !== 1'b0) begin failures++; $display("FAIL b2b_nack2 got=%b exp=0", nack_v[2]); end
    if (log_s != "S 42 12 80 P ") begin
      failures++; $display("FAIL b2b_bus got='%s' exp='S 42 12 80 P '", log_s);
    end
  endtask

  task automatic test_reset_mid;
    int bc, dc;
    sel = 0;
    @(negedge clk);
    start = 1; rw = 0; addr = 16'h0012; wdata = 8'h80;
    @(negedge clk);
    start = 0;
    repeat (200) @(negedge clk);
    rst_n = 0;
    #1;
    checks += 3;
    if (scl_v[0] !== 1'b1) begin failures++; $display("FAIL rm_scl got=%b exp=1", scl_v[0]); end
    if (oe_v[0] !== 1'b0) begin failures++; $display("FAIL rm_oe got=%b exp=0", oe_v[0]); end
    if (busy_v[0] !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", busy_v[0]); end
    @(negedge clk);
    rst_n = 1;
    repeat (20) @(negedge clk);
    run_txn(0, 0, 16'h0012, 8'h80, bc, dc);
    checks += 3;
    if (bc != 464) begin failures++; $display("FAIL rm_wr_busy got=%0d exp=464", bc); end
    if (nack_v[0] !== 1'b0) begin failures++; $display("FAIL rm_wr_nack got=%b exp=0", nack_v[0]); end
    if (log_s != "S 42 12 80 P ") begin
      failures++; $display("FAIL rm_wr_bus got='%s' exp='S 42 12 80 P '", log_s);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr16();
    test_nack();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
